// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Posted-write buffer between the LSU data-bus master ports and the data
// memory ports. Stores are acked on entry and drained to memory in FIFO order
// by a small drain FSM. Loads go straight to memory unless their word address
// matches a pending store (or a store is being presented the same cycle). In
// that case the load waits until the conflicting entry has drained.
//
// Drain FSM states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   D_IDLE  | no write outstanding on the memory port, mem_w_we = 0
//   D_WRITE | head entry presented on mem_w_*, waiting for mem_w_ack
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   up_w_we/addr/data/sel    LSU store request          -> up_w_ack
//   up_r_re/addr/sel         LSU load request           -> up_r_data/up_r_ack
//   mem_w_we/addr/data/sel   memory store request       <- mem_w_ack
//   mem_r_re/addr/sel        memory load request        <- mem_r_data/mem_r_ack
//   empty                    nothing pending and drain FSM idle
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              up_w_we,
  input  logic [XLEN-1:0]   up_w_addr,
  input  logic [XLEN-1:0]   up_w_data,
  input  logic [XLEN/8-1:0] up_w_sel,
  output logic              up_w_ack,

  input  logic              up_r_re,
  input  logic [XLEN-1:0]   up_r_addr,
  input  logic [XLEN/8-1:0] up_r_sel,
  output logic [XLEN-1:0]   up_r_data,
  output logic              up_r_ack,

  output logic              mem_w_we,
  output logic [XLEN-1:0]   mem_w_addr,
  output logic [XLEN-1:0]   mem_w_data,
  output logic [XLEN/8-1:0] mem_w_sel,
  input  logic              mem_w_ack,

  output logic              mem_r_re,
  output logic [XLEN-1:0]   mem_r_addr,
  output logic [XLEN/8-1:0] mem_r_sel,
  input  logic [XLEN-1:0]   mem_r_data,
  input  logic              mem_r_ack,

  output logic              empty
);

  localparam int SEL_W = XLEN / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    D_IDLE  = 1'b0,
    D_WRITE = 1'b1
  } drain_state_e;

  // Entry storage. Not reset: validity comes from count/rd_ptr only.
  logic [XLEN-1:0]  ent_addr_q [DEPTH];
  logic [XLEN-1:0]  ent_data_q [DEPTH];
  logic [SEL_W-1:0] ent_sel_q  [DEPTH];

  logic [CNT_W-1:0] count_q,  count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  drain_state_e     state_q,  state_d;
  logic             rd_busy_q, rd_busy_d;

  logic             full;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_after_pop;
  logic             addr_hit;
  logic             hazard;
  logic [PTR_W-1:0] offset;
  logic             mem_r_re_c;

  // -------------------------------------------------------------------------
  // Enqueue / pop bookkeeping
  // -------------------------------------------------------------------------
  always_comb begin
    full = (count_q == CNT_W'(DEPTH));
    push = up_w_we && !full;
    pop  = (state_q == D_WRITE) && mem_w_ack;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  end

  // -------------------------------------------------------------------------
  // Drain FSM next state. The decision to stay in D_WRITE looks at the
  // occupancy after this cycle's pop (including a same-cycle push), so a
  // store arriving while the last entry drains keeps the port busy.
  // -------------------------------------------------------------------------
  always_comb begin
    count_after_pop = count_d;
    state_d         = state_q;
    case (state_q)
      D_IDLE: begin
        if (count_q != '0) state_d = D_WRITE;
      end
      D_WRITE: begin
        if (mem_w_ack && (count_after_pop == '0)) state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Load hazard detection. An entry at physical slot i is valid when its
  // distance from rd_ptr (mod DEPTH) is below count. The head being drained
  // is still valid until the edge that pops it.
  // -------------------------------------------------------------------------
  always_comb begin
    addr_hit = 1'b0;
    offset   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, offset} < count_q) &&
          (ent_addr_q[i][XLEN-1:2] == up_r_addr[XLEN-1:2])) begin
        addr_hit = 1'b1;
      end
    end
    // A store presented this cycle wins over the load regardless of address.
    hazard = addr_hit || up_w_we;
  end

  // -------------------------------------------------------------------------
  // Read channel. Once a request has gone out it is held until the memory
  // acks, even if a conflicting store shows up meanwhile, so the memory
  // side never sees a request withdrawn.
  // -------------------------------------------------------------------------
  always_comb begin
    if (rd_busy_q) mem_r_re_c = 1'b1;
    else           mem_r_re_c = up_r_re && !hazard;

    rd_busy_d = rd_busy_q;
    if (rd_busy_q) begin
      if (mem_r_ack) rd_busy_d = 1'b0;
    end else if (mem_r_re_c && !mem_r_ack) begin
      rd_busy_d = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= D_IDLE;
      rd_busy_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[wr_ptr_q] <= up_w_addr;
      ent_data_q[wr_ptr_q] <= up_w_data;
      ent_sel_q[wr_ptr_q]  <= up_w_sel;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign up_w_ack   = push;

  assign mem_w_we   = (state_q == D_WRITE);
  assign mem_w_addr = ent_addr_q[rd_ptr_q];
  assign mem_w_data = ent_data_q[rd_ptr_q];
  assign mem_w_sel  = ent_sel_q[rd_ptr_q];

  assign mem_r_re   = mem_r_re_c;
  assign mem_r_addr = up_r_addr;
  assign mem_r_sel  = up_r_sel;

  assign up_r_ack   = mem_r_re_c && mem_r_ack;
  assign up_r_data  = mem_r_data;

  assign empty      = (count_q == '0) && (state_q == D_IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (XLEN=32, DEPTH=4).
// Inputs change 1ns after the rising edge, outputs are checked 1ns later.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        up_w_we;
  logic [31:0] up_w_addr;
  logic [31:0] up_w_data;
  logic [3:0]  up_w_sel;
  logic        up_w_ack;
  logic        up_r_re;
  logic [31:0] up_r_addr;
  logic [3:0]  up_r_sel;
  logic [31:0] up_r_data;
  logic        up_r_ack;
  logic        mem_w_we;
  logic [31:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic [3:0]  mem_w_sel;
  logic        mem_w_ack;
  logic        mem_r_re;
  logic [31:0] mem_r_addr;
  logic [3:0]  mem_r_sel;
  logic [31:0] mem_r_data;
  logic        mem_r_ack;
  logic        empty;

  int nvec = 0;
  int nerr = 0;

  store_buffer #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .up_w_we(up_w_we), .up_w_addr(up_w_addr), .up_w_data(up_w_data),
    .up_w_sel(up_w_sel), .up_w_ack(up_w_ack),
    .up_r_re(up_r_re), .up_r_addr(up_r_addr), .up_r_sel(up_r_sel),
    .up_r_data(up_r_data), .up_r_ack(up_r_ack),
    .mem_w_we(mem_w_we), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_w_sel(mem_w_sel), .mem_w_ack(mem_w_ack),
    .mem_r_re(mem_r_re), .mem_r_addr(mem_r_addr), .mem_r_sel(mem_r_sel),
    .mem_r_data(mem_r_data), .mem_r_ack(mem_r_ack),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    up_w_we = 0; up_w_addr = 0; up_w_data = 0; up_w_sel = 0;
    up_r_re = 0; up_r_addr = 0; up_r_sel = 0;
    mem_w_ack = 0; mem_r_ack = 0; mem_r_data = 0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    nvec++; if (up_w_ack !== 1'b0) begin nerr++; $display("FAIL rst_up_w_ack: got %0b want 0", up_w_ack); end
    nvec++; if (up_r_ack !== 1'b0) begin nerr++; $display("FAIL rst_up_r_ack: got %0b want 0", up_r_ack); end
    nvec++; if (mem_w_we !== 1'b0) begin nerr++; $display("FAIL rst_mem_w_we: got %0b want 0", mem_w_we); end
    nvec++; if (mem_r_re !== 1'b0) begin nerr++; $display("FAIL rst_mem_r_re: got %0b want 0", mem_r_re); end
    nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL rst_empty: got %0b want 1", empty); end
  endtask

  task automatic test_single_store();
    cyc();
    up_w_we = 1; up_w_addr = 32'h100; up_w_data = 32'hDEADBEEF; up_w_sel = 4'hF;
    #1;
    nvec++; if (up_w_ack !== 1'b1) begin nerr++; $display("FAIL single_ack: got %0b want 1", up_w_ack); end
    nvec++; if (mem_w_we !== 1'b0) begin nerr++; $display("FAIL single_we_t0: got %0b want 0", mem_w_we); end
    cyc();
    up_w_we = 0;
    #1;
    nvec++; if (mem_w_we !== 1'b0) begin nerr++; $display("FAIL single_we_t1: got %0b want 0", mem_w_we); end
    nvec++; if (empty !== 1'b0) begin nerr++; $display("FAIL single_empty_t1: got %0b want 0", empty); end
    cyc();
    #1;
    nvec++; if (mem_w_we !== 1'b1) begin nerr++; $display("FAIL single_we_t2: got %0b want 1", mem_w_we); end
    nvec++; if (mem_w_addr !== 32'h100) begin nerr++; $display("FAIL single_addr: got %h want 00000100", mem_w_addr); end
    nvec++; if (mem_w_data !== 32'hDEADBEEF) begin nerr++; $display("FAIL single_data: got %h want deadbeef", mem_w_data); end
    nvec++; if (mem_w_sel !== 4'hF) begin nerr++; $display("FAIL single_sel: got %h want f", mem_w_sel); end
    cyc();
    mem_w_ack = 1;
    #1;
    nvec++; if (mem_w_we !== 1'b1 || mem_w_data !== 32'hDEADBEEF) begin nerr++; $display("FAIL single_stable: we %0b data %h want 1 deadbeef", mem_w_we, mem_w_data); end
    cyc();
    mem_w_ack = 0;
    #1;
    nvec++; if (mem_w_we !== 1'b0) begin nerr++; $display("FAIL single_we_after: got %0b want 0", mem_w_we); end
    nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL single_empty_after: got %0b want 1", empty); end
  endtask

  task automatic test_fill();
    mem_w_ack = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      up_w_we = 1; up_w_addr = 32'h1000 + 32'(4*i); up_w_data = 32'hA000_0000 + 32'(i); up_w_sel = 4'hF;
      #1;
      nvec++; if (up_w_ack !== 1'b1) begin nerr++; $display("FAIL fill_ack%0d: got %0b want 1", i, up_w_ack); end
    end
    cyc();
    up_w_addr = 32'h1010; up_w_data = 32'hA000_0004; up_w_sel = 4'h3;
    #1;
    nvec++; if (up_w_ack !== 1'b0) begin nerr++; $display("FAIL fill_ack5_full: got %0b want 0", up_w_ack); end
    nvec++; if (mem_w_we !== 1'b1 || mem_w_addr !== 32'h1000) begin nerr++; $display("FAIL fill_head: we %0b addr %h want 1 00001000", mem_w_we, mem_w_addr); end
    cyc();
    mem_w_ack = 1;
    #1;
    nvec++; if (up_w_ack !== 1'b0) begin nerr++; $display("FAIL fill_no_pass: got %0b want 0", up_w_ack); end
    cyc();
    mem_w_ack = 0;
    #1;
    nvec++; if (up_w_ack !== 1'b1) begin nerr++; $display("FAIL fill_ack5: got %0b want 1", up_w_ack); end
    nvec++; if (mem_w_addr !== 32'h1004) begin nerr++; $display("FAIL fill_head2: got %h want 00001004", mem_w_addr); end
    cyc();
    up_w_addr = 32'h1014;
    #1;
    nvec++; if (up_w_ack !== 1'b0) begin nerr++; $display("FAIL fill_still_full: got %0b want 0", up_w_ack); end
    up_w_we = 0;
    mem_w_ack = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      nvec++; if (mem_w_we !== 1'b1 || mem_w_addr !== 32'h1004 + 32'(4*k) || mem_w_data !== 32'hA000_0001 + 32'(k))
        begin nerr++; $display("FAIL fill_drain%0d: we %0b addr %h data %h want 1 %h %h", k, mem_w_we, mem_w_addr, mem_w_data, 32'h1004 + 32'(4*k), 32'hA000_0001 + 32'(k)); end
      if (k == 3) begin
        nvec++; if (mem_w_sel !== 4'h3) begin nerr++; $display("FAIL fill_sel5: got %h want 3", mem_w_sel); end
      end
      cyc();
    end
    #1;
    nvec++; if (mem_w_we !== 1'b0 || empty !== 1'b1) begin nerr++; $display("FAIL fill_done: we %0b empty %0b want 0 1", mem_w_we, empty); end
    mem_w_ack = 0;
  endtask

  task automatic test_raw_hazard();
    cyc();
    up_w_we = 1; up_w_addr = 32'h200; up_w_data = 32'h55; up_w_sel = 4'hF;
    #1;
    nvec++; if (up_w_ack !== 1'b1) begin nerr++; $display("FAIL raw_st_ack: got %0b want 1", up_w_ack); end
    cyc();
    up_w_we = 0; up_r_re = 1; up_r_addr = 32'h202; up_r_sel = 4'b1100;
    #1;
    nvec++; if (mem_r_re !== 1'b0) begin nerr++; $display("FAIL raw_block1: got %0b want 0", mem_r_re); end
    cyc();
    #1;
    nvec++; if (mem_r_re !== 1'b0 || mem_w_we !== 1'b1) begin nerr++; $display("FAIL raw_block2: re %0b we %0b want 0 1", mem_r_re, mem_w_we); end
    cyc();
    mem_w_ack = 1; mem_r_data = 32'hCAFEF00D;
    #1;
    nvec++; if (mem_r_re !== 1'b0) begin nerr++; $display("FAIL raw_block_ackcyc: got %0b want 0", mem_r_re); end
    cyc();
    mem_w_ack = 0; mem_r_ack = 1;
    #1;
    nvec++; if (mem_r_re !== 1'b1) begin nerr++; $display("FAIL raw_release: got %0b want 1", mem_r_re); end
    nvec++; if (mem_r_addr !== 32'h202 || mem_r_sel !== 4'b1100) begin nerr++; $display("FAIL raw_fwd: addr %h sel %h want 00000202 c", mem_r_addr, mem_r_sel); end
    nvec++; if (up_r_ack !== 1'b1 || up_r_data !== 32'hCAFEF00D) begin nerr++; $display("FAIL raw_data: ack %0b data %h want 1 cafef00d", up_r_ack, up_r_data); end
    cyc();
    up_r_re = 0; mem_r_ack = 0;
    #1;
    nvec++; if (mem_r_re !== 1'b0 || up_r_ack !== 1'b0) begin nerr++; $display("FAIL raw_idle: re %0b ack %0b want 0 0", mem_r_re, up_r_ack); end
  endtask

  task automatic test_write_priority();
    cyc();
    up_w_we = 1; up_w_addr = 32'h600; up_w_data = 32'h66; up_w_sel = 4'hF;
    up_r_re = 1; up_r_addr = 32'h700; up_r_sel = 4'hF;
    #1;
    nvec++; if (mem_r_re !== 1'b0 || up_w_ack !== 1'b1) begin nerr++; $display("FAIL wprio_block: re %0b wack %0b want 0 1", mem_r_re, up_w_ack); end
    cyc();
    up_w_we = 0; mem_r_ack = 1; mem_r_data = 32'h1234_5678; mem_w_ack = 1;
    #1;
    nvec++; if (up_r_ack !== 1'b1 || up_r_data !== 32'h1234_5678) begin nerr++; $display("FAIL wprio_read: ack %0b data %h want 1 12345678", up_r_ack, up_r_data); end
    cyc();
    up_r_re = 0; mem_r_ack = 0;
    cyc();
    mem_w_ack = 0;
    #1;
    nvec++; if (empty !== 1'b1) begin nerr++; $display("FAIL wprio_drained: got %0b want 1", empty); end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 3; i++) begin
      cyc();
      up_w_we = 1; up_w_addr = 32'h300 + 32'(4*i); up_w_data = 32'h3000 + 32'(i); up_w_sel = 4'hF;
      #1;
      nvec++; if (up_w_ack !== 1'b1) begin nerr++; $display("FAIL byp_st_ack%0d: got %0b want 1", i, up_w_ack); end
    end
    cyc();
    up_w_we = 0; up_r_re = 1; up_r_addr = 32'h400; up_r_sel = 4'hF; mem_r_data = 32'hBEEF_0400;
    #1;
    nvec++; if (mem_r_re !== 1'b1) begin nerr++; $display("FAIL byp_re_same_cycle: got %0b want 1", mem_r_re); end
    cyc();
    mem_r_ack = 1;
    #1;
    nvec++; if (mem_r_re !== 1'b1 || up_r_ack !== 1'b1) begin nerr++; $display("FAIL byp_ack: re %0b ack %0b want 1 1", mem_r_re, up_r_ack); end
    nvec++; if (up_r_data !== 32'hBEEF_0400) begin nerr++; $display("FAIL byp_data: got %h want beef0400", up_r_data); end
    nvec++; if (mem_w_we !== 1'b1) begin nerr++; $display("FAIL byp_drain_busy: got %0b want 1", mem_w_we); end
    cyc();
    up_r_re = 0; mem_r_ack = 0;
    #1;
    nvec++; if (mem_r_re !== 1'b0) begin nerr++; $display("FAIL byp_busy_clear: got %0b want 0", mem_r_re); end
  endtask

  task automatic test_reset_mid_drain();
    nvec++; if (mem_w_we !== 1'b1 || empty !== 1'b0) begin nerr++; $display("FAIL rmd_pre: we %0b empty %0b want 1 0", mem_w_we, empty); end
    reset = 1;
    cyc();
    reset = 0;
    #1;
    nvec++; if (mem_w_we !== 1'b0 || empty !== 1'b1) begin nerr++; $display("FAIL rmd_post: we %0b empty %0b want 0 1", mem_w_we, empty); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      nvec++; if (mem_w_we !== 1'b0) begin nerr++; $display("FAIL rmd_quiet%0d: got %0b want 0", i, mem_w_we); end
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    up_w_we = 1; up_w_addr = 32'h500; up_w_data = 32'h5000; up_w_sel = 4'hF;
    #1;
    nvec++; if (up_w_ack !== 1'b1) begin nerr++; $display("FAIL b2b_ack0: got %0b want 1", up_w_ack); end
    cyc();
    up_w_addr = 32'h504; up_w_data = 32'h5004; mem_w_ack = 1;
    #1;
    nvec++; if (up_w_ack !== 1'b1 || mem_w_we !== 1'b0) begin nerr++; $display("FAIL b2b_ack1: ack %0b we %0b want 1 0", up_w_ack, mem_w_we); end
    cyc();
    up_w_we = 0;
    #1;
    nvec++; if (mem_w_we !== 1'b1 || mem_w_addr !== 32'h500) begin nerr++; $display("FAIL b2b_x0: we %0b addr %h want 1 00000500", mem_w_we, mem_w_addr); end
    cyc();
    #1;
    nvec++; if (mem_w_we !== 1'b1 || mem_w_addr !== 32'h504 || mem_w_data !== 32'h5004) begin nerr++; $display("FAIL b2b_x1: we %0b addr %h data %h want 1 00000504 00005004", mem_w_we, mem_w_addr, mem_w_data); end
    cyc();
    #1;
    nvec++; if (mem_w_we !== 1'b0 || empty !== 1'b1) begin nerr++; $display("FAIL b2b_drop: we %0b empty %0b want 0 1", mem_w_we, empty); end
    mem_w_ack = 0;
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_fill();
    test_raw_hazard();
    test_write_priority();
    test_bypass();
    test_reset_mid_drain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
